ii_window_loader: RTL
=====================

II_WINDOW_LOADER -- requirements
Module: ii_window_loader

Interface
REQ-001 Parameter LENGHT_LINE_II, default 21: integral-image line length; the pixel window is (LENGHT_LINE_II-1)², i.e. 20x20 by default.
REQ-002 Parameter ADDR_WIDTH_II, default $clog2(LENGHT_LINE_II*LENGHT_LINE_II): integral-image RAM address width.
REQ-003 clk_i  in  1  single clock; all logic is rising-edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 pix_data_i  in  8  pixel, window raster order (row-major).
REQ-006 pix_val_i  in  1  pixel valid.
REQ-007 pix_ready_o  out  1  pixel accepted when pix_val_i & pix_ready_o.
REQ-008 norm_factor_i  in  32  variance normalisation factor for the window, sampled with the first pixel.
REQ-009 ii_addr_wr_o  out  ADDR_WIDTH_II  integral-image RAM write address.
REQ-010 ii_data_wr_o  out  32  integral-image RAM write data.
REQ-011 ii_val_wr_o  out  1  RAM write enable.
REQ-012 variance_norm_factor_o  out  32  latched norm factor to the classifier.
REQ-013 start_o  out  1  one-cycle classifier start pulse.
REQ-014 done_i  in  1  classifier done.
REQ-015 result_i  in  1  classifier result, valid with done_i.
REQ-016 result_o  out  1  captured result.
REQ-017 result_val_o  out  1  one-cycle result strobe.
REQ-018 busy_o  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, CLEAR, LOAD, START, WAIT, REPORT.
REQ-020 IDLE -> CLEAR when pix_val_i=1; pix_ready_o=0 in IDLE.
REQ-021 CLEAR writes 0 to row 0 (addr 0..L-1) and then to column 0 (addr r*L, r=1..L-1), one write per cycle (41 cycles at L=21), then -> LOAD; pix_ready_o=0 throughout.
REQ-022 LOAD: pix_ready_o=1; on each accepted pixel at window (r,c), r,c in 0..L-2, write addr (r+1)*L+(c+1), data = ii(r,c+1) + rowsum, where rowsum is the running sum of row r up to and including column c; the write appears 1 cycle after acceptance.
REQ-023 The previous integral-image row is kept in an internal (L-1)-entry x 32-bit line buffer; the RAM is never read.
REQ-024 rowsum clears at c=0; arithmetic is unsigned and zero-extended to 32 bits; maximum value 102000 at L=21, no overflow.
REQ-025 pix_val_i low in LOAD stalls: counters hold and no write is issued.
REQ-026 norm_factor_i is latched on acceptance of pixel (0,0) and held on variance_norm_factor_o until the next window's (0,0).
REQ-027 After the last pixel's write, -> START: start_o=1 for exactly one cycle, then -> WAIT.
REQ-028 done_i is sampled only in WAIT; done_i in any other state is ignored.
REQ-029 WAIT -> REPORT on done_i=1, capturing result_i into result_o.
REQ-030 REPORT: result_val_o=1 for one cycle, then -> IDLE; result_o holds until the next capture.
REQ-031 pix_val_i in START, WAIT or REPORT is not accepted (pix_ready_o=0).

Reset
REQ-032 On rst_i=0: FSM=IDLE; counters, rowsum and line buffer cleared; all outputs 0 (pix_ready_o, ii_*, start_o, result_o, result_val_o, busy_o, variance_norm_factor_o).
REQ-033 Reset mid-window aborts it with no further RAM write or start_o; the next window restarts at CLEAR.

Configuration
REQ-034 Macro II_WINDOW_SQSUM_EN: when defined, adds outputs sum_o[31:0] (pixel sum) and sqsum_o[31:0] (sum of squared pixels), both reset to 0, cleared at CLEAR, updated per accepted pixel and stable from the start_o cycle until the next CLEAR; when undefined, these ports and their logic are absent.

Verification
REQ-035 All pixels = 1, no stalls -> RAM word at r*21+c equals r*c for all r,c; word 440 = 400; one start_o 1 cycle after the last write.
REQ-036 Pixel(r,c) = r+c, pix_val_i toggled 1/0 every cycle -> word 440 = 7600; no write issued in stall cycles.
REQ-037 norm_factor_i = 0x1234 at pixel (0,0), then changed -> variance_norm_factor_o = 0x1234 through WAIT.
REQ-038 done_i=1 with result_i=1 pulsed during LOAD, then again 3 cycles after start_o -> the first is ignored; result_o=1 and result_val_o pulses once, then IDLE.
REQ-039 rst_i low after 150 pixels -> all outputs 0 next cycle; the following full window of 1s reproduces REQ-035 exactly.
REQ-040 II_WINDOW_SQSUM_EN defined, all pixels 255 -> sum_o = 102000 and sqsum_o = 26010000 at start_o.

Source files
------------

// File: rtl/ii_window_loader_if.sv
// Pixel, integral-image RAM write and classifier handshake signals of ii_window_loader.
// II_WINDOW_SQSUM_EN adds the sum_o / sqsum_o window statistics.
interface ii_window_loader_if #(
    parameter int ADDR_WIDTH_II = 9
);
    logic [7:0]               pix_data_i;
    logic                     pix_val_i;
    logic                     pix_ready_o;
    logic [31:0]              norm_factor_i;
    logic [ADDR_WIDTH_II-1:0] ii_addr_wr_o;
    logic [31:0]              ii_data_wr_o;
    logic                     ii_val_wr_o;
    logic [31:0]              variance_norm_factor_o;
    logic                     start_o;
    logic                     done_i;
    logic                     result_i;
    logic                     result_o;
    logic                     result_val_o;
    logic                     busy_o;
`ifdef II_WINDOW_SQSUM_EN
    logic [31:0]              sum_o;
    logic [31:0]              sqsum_o;
`endif

    // Loader side: consumes pixels and classifier status, drives RAM and classifier.
    modport master (
        input  pix_data_i, pix_val_i, norm_factor_i, done_i, result_i,
        output pix_ready_o, ii_addr_wr_o, ii_data_wr_o, ii_val_wr_o,
        output variance_norm_factor_o, start_o, result_o, result_val_o, busy_o
`ifdef II_WINDOW_SQSUM_EN
        , output sum_o, sqsum_o
`endif
    );

    // Environment side: pixel source, RAM and classifier.
    modport slave (
        output pix_data_i, pix_val_i, norm_factor_i, done_i, result_i,
        input  pix_ready_o, ii_addr_wr_o, ii_data_wr_o, ii_val_wr_o,
        input  variance_norm_factor_o, start_o, result_o, result_val_o, busy_o
`ifdef II_WINDOW_SQSUM_EN
        , input sum_o, sqsum_o
`endif
    );
endinterface

// File: rtl/ii_window_loader.sv
// Streams a (L-1)x(L-1) pixel window into an L x L integral-image RAM, then runs the classifier.
// Optional feature macro: II_WINDOW_SQSUM_EN (pixel sum and squared-pixel sum outputs).
module ii_window_loader #(
    parameter int LENGHT_LINE_II = 21,
    parameter int ADDR_WIDTH_II  = $clog2(LENGHT_LINE_II * LENGHT_LINE_II)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ii_window_loader_if.master  bus
);
    localparam int L        = LENGHT_LINE_II;
    localparam int W        = L - 1;
    localparam int CNT_W    = $clog2(L);
    localparam int CLR_LAST = 2 * L - 2;
    localparam int CLR_W    = $clog2(2 * L);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_LOAD, ST_START, ST_WAIT, ST_REPORT
    } state_t;

    state_t                   state, state_nxt;
    logic [CLR_W-1:0]         clr_cnt;
    logic [CNT_W-1:0]         row_cnt, col_cnt;
    logic [31:0]              rowsum;
    logic [31:0]              line_buf [W];
    logic                     load_end;
    logic                     accept, last_pix, clr_done;
    logic [31:0]              pix_ext, rowsum_nxt, ii_nxt;
    logic [ADDR_WIDTH_II-1:0] clr_addr, load_addr;

    // load_end marks the cycle the final pixel's write is on the bus; no pixel is taken then.
    assign bus.pix_ready_o  = (state == ST_LOAD) && !load_end;
    assign bus.start_o      = (state == ST_START);
    assign bus.result_val_o = (state == ST_REPORT);
    assign bus.busy_o       = (state != ST_IDLE);

    assign accept   = bus.pix_val_i && bus.pix_ready_o;
    assign last_pix = (row_cnt == CNT_W'(W - 1)) && (col_cnt == CNT_W'(W - 1));
    assign clr_done = (clr_cnt == CLR_W'(CLR_LAST));
    assign pix_ext  = {24'd0, bus.pix_data_i};

    // ii(r+1,c+1) = ii(r,c+1) + running row sum; row 0 of the integral image is all zero.
    assign rowsum_nxt = ((col_cnt == '0) ? 32'd0 : rowsum) + pix_ext;
    assign ii_nxt     = ((row_cnt == '0) ? 32'd0 : line_buf[col_cnt]) + rowsum_nxt;

    assign clr_addr  = (int'(clr_cnt) < L) ? ADDR_WIDTH_II'(clr_cnt)
                                           : ADDR_WIDTH_II'((int'(clr_cnt) - L + 1) * L);
    assign load_addr = ADDR_WIDTH_II'((int'(row_cnt) + 1) * L + int'(col_cnt) + 1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.pix_val_i) state_nxt = ST_CLEAR;
            ST_CLEAR:  if (clr_done)      state_nxt = ST_LOAD;
            ST_LOAD:   if (load_end)      state_nxt = ST_START;
            ST_START:                     state_nxt = ST_WAIT;
            ST_WAIT:   if (bus.done_i)    state_nxt = ST_REPORT;
            ST_REPORT:                    state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            clr_cnt                    <= '0;
            row_cnt                    <= '0;
            col_cnt                    <= '0;
            rowsum                     <= '0;
            load_end                   <= 1'b0;
            bus.ii_addr_wr_o           <= '0;
            bus.ii_data_wr_o           <= '0;
            bus.ii_val_wr_o            <= 1'b0;
            bus.variance_norm_factor_o <= '0;
            bus.result_o               <= 1'b0;
`ifdef II_WINDOW_SQSUM_EN
            bus.sum_o                  <= '0;
            bus.sqsum_o                <= '0;
`endif
        end else begin
            bus.ii_val_wr_o <= 1'b0;
            load_end        <= accept && last_pix;

            if (state == ST_CLEAR) begin
                clr_cnt          <= clr_cnt + CLR_W'(1);
                bus.ii_addr_wr_o <= clr_addr;
                bus.ii_data_wr_o <= '0;
                bus.ii_val_wr_o  <= 1'b1;
                row_cnt          <= '0;
                col_cnt          <= '0;
                rowsum           <= '0;
`ifdef II_WINDOW_SQSUM_EN
                bus.sum_o        <= '0;
                bus.sqsum_o      <= '0;
`endif
            end else begin
                clr_cnt <= '0;
            end

            if (accept) begin
                bus.ii_addr_wr_o <= load_addr;
                bus.ii_data_wr_o <= ii_nxt;
                bus.ii_val_wr_o  <= 1'b1;
                rowsum           <= rowsum_nxt;
                if (row_cnt == '0 && col_cnt == '0)
                    bus.variance_norm_factor_o <= bus.norm_factor_i;
                if (col_cnt == CNT_W'(W - 1)) begin
                    col_cnt <= '0;
                    row_cnt <= last_pix ? '0 : row_cnt + CNT_W'(1);
                end else begin
                    col_cnt <= col_cnt + CNT_W'(1);
                end
`ifdef II_WINDOW_SQSUM_EN
                bus.sum_o   <= bus.sum_o + pix_ext;
                bus.sqsum_o <= bus.sqsum_o + pix_ext * pix_ext;
`endif
            end

            if (state == ST_WAIT && bus.done_i)
                bus.result_o <= bus.result_i;
        end
    end

    // NOTE: the line buffer is small flop storage, so it takes the async clear; row 0 never reads it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < W; i++) line_buf[i] <= '0;
        end else if (accept) begin
            line_buf[col_cnt] <= ii_nxt;
        end
    end
endmodule
